// File: rtl/ads5296_tx_pkg.sv
// ADS5296 transmit emulator shared definitions.
// Mode encodings, frame/word/sample widths and the sample-to-lane bit split.
package ads5296_tx_pkg;

    typedef enum logic [1:0] {
        MODE_USER   = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_CONST  = 2'd2,
        MODE_TOGGLE = 2'd3
    } tx_mode_e;

    localparam int FRAME_BITS = 5;   // bits per lane per frame
    localparam int WORD_W     = 4;   // parallel word width per lclk_d4 cycle
    localparam int SAMPLE_W   = 10;  // ADC sample width
    localparam int BUF_W      = 9;   // gearbox holding buffer (max 4 left + 5 new)

    localparam logic [2:0] PH_LAST = 3'd4;  // no frame is loaded in this phase

    // Lane 0 carries the odd sample bits, lane 1 the even ones.
    // Result is MSB-first: bit 4 is the first bit on the wire.
    function automatic logic [FRAME_BITS-1:0] lane_bits(input logic [SAMPLE_W-1:0] s,
                                                        input logic lane1);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        for (int j = 0; j < FRAME_BITS; j++)
            f[FRAME_BITS-1-j] = s[SAMPLE_W-1-2*j-int'(lane1)];
        return f;
    endfunction

endpackage

// File: rtl/ads5296_tx_if.sv
// Sample-word stream between user logic and the ADS5296 emulator.
//   s_valid : sample word valid (master)
//   s_ready : word taken this cycle when high with s_valid (slave)
//   s_data  : one 10-bit sample per channel, channel c at [10c+9:10c]
interface ads5296_tx_if #(
    parameter int G_NUM_CH = 4
);
    import ads5296_tx_pkg::*;

    logic                         s_valid;
    logic                         s_ready;
    logic [SAMPLE_W*G_NUM_CH-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ads5296_tx_lane.sv
// One serial lane: 5:4 gearbox plus a bit-slip barrel.
//   ph          : gearbox phase 0..4; equals buffer occupancy before this cycle
//   load        : append frame this cycle
//   frame       : 5 lane bits, MSB transmitted first
//   slip_ofs    : data delay in bits (0..3)
//   bypass_slip : output the gearbox word directly (used for fclk)
//   dout        : registered 4-bit word, bit 0 transmitted first
module ads5296_tx_lane
    import ads5296_tx_pkg::*;
(
    input  logic                  lclk_d4,
    input  logic                  rst,
    input  logic                  en,
    input  logic [2:0]            ph,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic [1:0]            slip_ofs,
    input  logic                  bypass_slip,
    output logic [WORD_W-1:0]     dout
);

    logic [BUF_W-1:0]      bit_buf;    // bit 0 = oldest pending bit
    logic [WORD_W-1:0]     prev_word;
    logic [FRAME_BITS-1:0] frame_tx;   // frame in wire order, bit 0 first
    logic [BUF_W-1:0]      merged;
    logic [WORD_W-1:0]     raw_word;
    logic [2*WORD_W-1:0]   pair_sh;
    logic [WORD_W-1:0]     slip_word;

    always_comb begin
        frame_tx = '0;
        for (int j = 0; j < FRAME_BITS; j++)
            frame_tx[j] = frame[FRAME_BITS-1-j];
        // Occupancy before output equals ph, so the new frame lands right
        // after the bits still waiting in the buffer.
        merged = bit_buf;
        if (load)
            merged = bit_buf | (BUF_W'(frame_tx) << ph);
        raw_word = merged[WORD_W-1:0];
        // Delay by slip_ofs bits: window into {current, previous} word.
        pair_sh   = {raw_word, prev_word} >> (WORD_W - int'(slip_ofs));
        slip_word = pair_sh[WORD_W-1:0];
    end

    always_ff @(posedge lclk_d4) begin
        if (rst || !en) begin
            bit_buf   <= '0;
            prev_word <= '0;
            dout      <= '0;
        end else begin
            bit_buf   <= merged >> WORD_W;
            prev_word <= raw_word;
            dout      <= bypass_slip ? raw_word : slip_word;
        end
    end

endmodule

// File: rtl/ads5296_tx_emulator.sv
// ADS5296 emulator, 10-bit 2-wire mode. Builds 4-bit parallel words for the
// frame clock and 2 data lanes per channel for downstream 4:1 serializers.
//   lclk_d4, rst  : word clock, synchronous active-high reset
//   en            : transmit enable (low clears datapath, holds counters)
//   mode          : 0 user stream, 1 ramp, 2 constant, 3 toggle
//   const_val     : sample for modes 2/3
//   s_if          : user sample stream (slave side)
//   slip          : pulse, delays data lanes one more bit vs fclk
//   dout          : lane 2c+l word at [4(2c+l)+3:4(2c+l)]
//   fclk_out      : frame-clock word
//   slip_ofs      : current data bit offset
//   frame_cnt     : frames emitted (wraps)
//   underflow_cnt : user-mode frames without a sample (saturates)
module ads5296_tx_emulator
    import ads5296_tx_pkg::*;
#(
    parameter int                    G_NUM_CH       = 4,
    parameter logic [FRAME_BITS-1:0] G_FCLK_PATTERN = 5'b11100
) (
    input  logic                    lclk_d4,
    input  logic                    rst,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic [SAMPLE_W-1:0]     const_val,
    ads5296_tx_if.slave             s_if,
    input  logic                    slip,
    output logic [8*G_NUM_CH-1:0]   dout,
    output logic [WORD_W-1:0]       fclk_out,
    output logic [1:0]              slip_ofs,
    output logic [31:0]             frame_cnt,
    output logic [15:0]             underflow_cnt
);

    localparam int NUM_LANES = 2 * G_NUM_CH;

    tx_mode_e                                   mode_e;
    logic [2:0]                                 ph;
    logic                                       load;
    logic [SAMPLE_W-1:0]                        ramp;
    logic                                       tog;
    logic [G_NUM_CH-1:0][SAMPLE_W-1:0]          sample;
    logic [NUM_LANES-1:0][FRAME_BITS-1:0]       lane_frame;
    logic [NUM_LANES-1:0][WORD_W-1:0]           lane_dout;

    assign mode_e      = tx_mode_e'(mode);
    assign load        = en && (ph != PH_LAST);
    assign s_if.s_ready = load && (mode_e == MODE_USER);

    always_comb begin
        sample = '0;
        case (mode_e)
            MODE_USER:   sample = s_if.s_valid ? s_if.s_data : '0;
            MODE_RAMP:   sample = {G_NUM_CH{ramp}};
            MODE_CONST:  sample = {G_NUM_CH{const_val}};
            MODE_TOGGLE: sample = {G_NUM_CH{tog ? ~const_val : const_val}};
            default:     sample = '0;
        endcase
    end

    always_ff @(posedge lclk_d4) begin
        if (rst) begin
            ph            <= '0;
            ramp          <= '0;
            tog           <= 1'b0;
            slip_ofs      <= '0;
            frame_cnt     <= '0;
            underflow_cnt <= '0;
        end else begin
            if (en && slip)
                slip_ofs <= slip_ofs + 2'd1;
            if (!en) begin
                ph   <= '0;
                ramp <= '0;
                tog  <= 1'b0;
            end else begin
                ph <= (ph == PH_LAST) ? 3'd0 : ph + 3'd1;
                if (load) begin
                    frame_cnt <= frame_cnt + 32'd1;
                    case (mode_e)
                        MODE_RAMP:   ramp <= ramp + 10'd1;
                        MODE_TOGGLE: tog  <= ~tog;
                        MODE_USER:
                            if (!s_if.s_valid && underflow_cnt != 16'hFFFF)
                                underflow_cnt <= underflow_cnt + 16'd1;
                        default: ;
                    endcase
                end
            end
        end
    end

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        assign lane_frame[n] = lane_bits(sample[n/2], 1'(n % 2));

        ads5296_tx_lane u_lane (
            .lclk_d4     (lclk_d4),
            .rst         (rst),
            .en          (en),
            .ph          (ph),
            .load        (load),
            .frame       (lane_frame[n]),
            .slip_ofs    (slip_ofs),
            .bypass_slip (1'b0),
            .dout        (lane_dout[n])
        );
    end

    assign dout = lane_dout;

    ads5296_tx_lane u_fclk (
        .lclk_d4     (lclk_d4),
        .rst         (rst),
        .en          (en),
        .ph          (ph),
        .load        (load),
        .frame       (G_FCLK_PATTERN),
        .slip_ofs    (slip_ofs),
        .bypass_slip (1'b1),
        .dout        (fclk_out)
    );

endmodule
